// File: rtl/sreg_pkg.sv
// ---------------------------------------------------------------------------
// sreg_pkg
//   Shared defaults and helpers for the scalar register file.
//   Revision: 1.0 - initial parametrised release
// ---------------------------------------------------------------------------
`default_nettype none

package sreg_pkg;

  // Defaults match the legacy eight-entry, 16-bit scalar bank.
  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_NREGS  = 8;

  // Every stored bit and every output register clears to this value.
  localparam logic RESET_BIT = 1'b0;

  // Number of 8-bit lanes in a data word.
  function automatic int byte_lanes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sreg_byte_merge.sv
// ---------------------------------------------------------------------------
// sreg_byte_merge
//   Combinational byte-lane merge: lanes with byte_en set come from new_word,
//   the rest from old_word.
//   Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sreg_byte_merge
  import sreg_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic [DATA_W-1:0]   old_word,
  input  logic [DATA_W-1:0]   new_word,
  input  logic [DATA_W/8-1:0] byte_en,
  output logic [DATA_W-1:0]   merged
);

  localparam int LANES = byte_lanes(DATA_W);

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign merged[8*i +: 8] = byte_en[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/sreg_file.sv
// ---------------------------------------------------------------------------
// sreg_file
//   Parametrised scalar register file: two registered read ports with
//   byte-lane write bypass, one byte-masked write port and a per-register
//   busy scoreboard.
//   Revision: 1.0 - initial parametrised release
// ---------------------------------------------------------------------------
`default_nettype none

module sreg_file
  import sreg_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int NREGS  = DEFAULT_NREGS,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                RdEnA,
  input  logic [ADDR_W-1:0]   RdAddrA,
  output logic [DATA_W-1:0]   RdDataA,
  output logic                RdValidA,
  input  logic                RdEnB,
  input  logic [ADDR_W-1:0]   RdAddrB,
  output logic [DATA_W-1:0]   RdDataB,
  output logic                RdValidB,
  input  logic                WrEn,
  input  logic [ADDR_W-1:0]   WrAddr,
  input  logic [DATA_W-1:0]   WrData,
  input  logic [DATA_W/8-1:0] WrByteEn,
  input  logic                ResEn,
  input  logic [ADDR_W-1:0]   ResAddr,
  output logic [NREGS-1:0]    Busy
);

  localparam logic [DATA_W-1:0] RESET_WORD = {DATA_W{RESET_BIT}};
  localparam int                NPORTS     = 2;

  logic [DATA_W-1:0]                regs [NREGS];
  logic [NREGS-1:0]                 busy_q;
  logic                             wr_in;
  logic                             res_in;
  logic [NPORTS-1:0]                rd_in;
  logic                             wr_ok;
  logic                             res_ok;
  logic [DATA_W-1:0]                wr_old;
  logic [DATA_W-1:0]                wr_word;
  logic [NPORTS-1:0]                rd_en;
  logic [NPORTS-1:0][ADDR_W-1:0]    rd_addr;
  logic [NPORTS-1:0]                wr_hit;
  logic [NPORTS-1:0][DATA_W-1:0]    base_word;
  logic [NPORTS-1:0][DATA_W-1:0]    bypass_word;
  logic [NPORTS-1:0][DATA_W/8-1:0]  hit_be;
  logic [NPORTS-1:0]                accept;
  logic [NPORTS-1:0][DATA_W-1:0]    data_q;
  logic [NPORTS-1:0]                valid_q;

  assign rd_en   = {RdEnB, RdEnA};
  assign rd_addr = {RdAddrB, RdAddrA};

  // Address range checks; with a power-of-two depth every code is valid.
  generate
    if (NREGS == (1 << ADDR_W)) begin : g_pow2
      assign wr_in  = 1'b1;
      assign res_in = 1'b1;
      assign rd_in  = '1;
    end else begin : g_partial
      localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NREGS);
      assign wr_in    = {1'b0, WrAddr}  < LIMIT;
      assign res_in   = {1'b0, ResAddr} < LIMIT;
      assign rd_in[0] = {1'b0, RdAddrA} < LIMIT;
      assign rd_in[1] = {1'b0, RdAddrB} < LIMIT;
    end
  endgenerate

  assign wr_ok  = WrEn  & wr_in;
  assign res_ok = ResEn & res_in;

  // Current contents of the write target, to be merged with the new bytes.
  always_comb begin
    wr_old = RESET_WORD;
    if (wr_in) wr_old = regs[WrAddr];
  end

  sreg_byte_merge #(.DATA_W(DATA_W)) u_wr_merge (
    .old_word (wr_old),
    .new_word (WrData),
    .byte_en  (WrByteEn),
    .merged   (wr_word)
  );

  // Per-port array lookup, write-hit detection and acceptance.
  // Out-of-range reads see zero and are always accepted.
  always_comb begin
    base_word = '0;
    wr_hit    = '0;
    hit_be    = '0;
    accept    = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (rd_in[p]) base_word[p] = regs[rd_addr[p]];
      wr_hit[p] = wr_ok && (WrAddr == rd_addr[p]);
      if (wr_hit[p]) hit_be[p] = WrByteEn;
      accept[p] = rd_en[p] && !(rd_in[p] && busy_q[rd_addr[p]] && !wr_hit[p]);
    end
  end

  generate
    for (genvar gp = 0; gp < NPORTS; gp++) begin : g_bypass
      sreg_byte_merge #(.DATA_W(DATA_W)) u_rd_merge (
        .old_word (base_word[gp]),
        .new_word (WrData),
        .byte_en  (hit_be[gp]),
        .merged   (bypass_word[gp])
      );
    end
  endgenerate

  // Register array and scoreboard; a reserve overrides a same-cycle write clear.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= RESET_WORD;
      busy_q <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (wr_ok && (WrAddr == ADDR_W'(r))) begin
          regs[r]   <= wr_word;
          busy_q[r] <= 1'b0;
        end
        if (res_ok && (ResAddr == ADDR_W'(r))) busy_q[r] <= 1'b1;
      end
    end
  end

  // Read output registers; data only moves on an accepted read.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        valid_q[p] <= accept[p];
        if (accept[p]) data_q[p] <= bypass_word[p];
      end
    end
  end

  assign RdDataA  = data_q[0];
  assign RdValidA = valid_q[0];
  assign RdDataB  = data_q[1];
  assign RdValidB = valid_q[1];
  assign Busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_sreg_file.sv
// ---------------------------------------------------------------------------
// tb_sreg_file
//   Scoreboard bench for sreg_file: default 8x16 instance and a 6x32
//   instance with out-of-range addresses.
//   Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sreg_file;

  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;

  typedef struct packed {
    logic        v;
    logic [31:0] d;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8 x 16 instance
  logic        rst = 1'b1, rd_en_a = 1'b0, rd_en_b = 1'b0, wr_en = 1'b0, res_en = 1'b0;
  logic [2:0]  rd_addr_a = '0, rd_addr_b = '0, wr_addr = '0, res_addr = '0;
  logic [15:0] wr_data = '0, rd_data_a, rd_data_b;
  logic [1:0]  wr_be = '0;
  logic        rd_valid_a, rd_valid_b;
  logic [7:0]  busy;

  // 6 x 32 instance
  logic        c_rst = 1'b1, c_rd_en_a = 1'b0, c_rd_en_b = 1'b0, c_wr_en = 1'b0, c_res_en = 1'b0;
  logic [2:0]  c_rd_addr_a = '0, c_rd_addr_b = '0, c_wr_addr = '0, c_res_addr = '0;
  logic [31:0] c_wr_data = '0, c_rd_data_a, c_rd_data_b;
  logic [3:0]  c_wr_be = '0;
  logic        c_rd_valid_a, c_rd_valid_b;
  logic [5:0]  c_busy;

  sreg_file u_dut (
    .Clk(clk), .Rst(rst),
    .RdEnA(rd_en_a), .RdAddrA(rd_addr_a), .RdDataA(rd_data_a), .RdValidA(rd_valid_a),
    .RdEnB(rd_en_b), .RdAddrB(rd_addr_b), .RdDataB(rd_data_b), .RdValidB(rd_valid_b),
    .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data), .WrByteEn(wr_be),
    .ResEn(res_en), .ResAddr(res_addr), .Busy(busy)
  );

  sreg_file #(.DATA_W(32), .NREGS(6)) u_dut6 (
    .Clk(clk), .Rst(c_rst),
    .RdEnA(c_rd_en_a), .RdAddrA(c_rd_addr_a), .RdDataA(c_rd_data_a), .RdValidA(c_rd_valid_a),
    .RdEnB(c_rd_en_b), .RdAddrB(c_rd_addr_b), .RdDataB(c_rd_data_b), .RdValidB(c_rd_valid_b),
    .WrEn(c_wr_en), .WrAddr(c_wr_addr), .WrData(c_wr_data), .WrByteEn(c_wr_be),
    .ResEn(c_res_en), .ResAddr(c_res_addr), .Busy(c_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model, indexed by instance (0 = 8x16, 1 = 6x32)
  logic [31:0] m_mem  [2][8];
  logic [7:0]  m_busy [2];
  logic [31:0] m_last [2][2];

  exp_t       q_a[$];
  exp_t       q_b[$];
  logic [7:0] q_busy[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nregs(input int d);
    return (d == 0) ? 8 : 6;
  endfunction

  function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  // Expected read result for one port, evaluated against pre-edge model state.
  function automatic exp_t port_exp(input int d, input logic rs, input logic en, input logic [2:0] a,
                                    input logic we, input logic [2:0] wa, input logic [31:0] wd,
                                    input logic [3:0] wbe, input int p);
    exp_t e;
    logic hit;
    e.v = 1'b0;
    if (rs) begin
      m_last[d][p] = '0;
    end else if (en) begin
      if (int'(a) >= nregs(d)) begin
        e.v = 1'b1;
        m_last[d][p] = '0;
      end else begin
        hit = we && (wa == a);
        e.v = !m_busy[d][a] || hit;
        if (e.v) m_last[d][p] = hit ? merge32(m_mem[d][a], wd, wbe) : m_mem[d][a];
      end
    end
    e.d = m_last[d][p];
    return e;
  endfunction

  task automatic step(input int d, input logic rs, input logic ea, input logic [2:0] aa,
                      input logic eb, input logic [2:0] ab, input logic we, input logic [2:0] wa,
                      input logic [31:0] wd, input logic [3:0] wbe, input logic re, input logic [2:0] ra);
    exp_t e;
    if (d == 0) begin
      wd[31:16] = '0;
      wbe[3:2]  = '0;
      rst = rs; rd_en_a = ea; rd_addr_a = aa; rd_en_b = eb; rd_addr_b = ab;
      wr_en = we; wr_addr = wa; wr_data = wd[15:0]; wr_be = wbe[1:0];
      res_en = re; res_addr = ra;
    end else begin
      c_rst = rs; c_rd_en_a = ea; c_rd_addr_a = aa; c_rd_en_b = eb; c_rd_addr_b = ab;
      c_wr_en = we; c_wr_addr = wa; c_wr_data = wd; c_wr_be = wbe;
      c_res_en = re; c_res_addr = ra;
    end
    q_a.push_back(port_exp(d, rs, ea, aa, we, wa, wd, wbe, 0));
    q_b.push_back(port_exp(d, rs, eb, ab, we, wa, wd, wbe, 1));
    if (rs) begin
      for (int i = 0; i < 8; i++) m_mem[d][i] = '0;
      m_busy[d] = '0;
    end else begin
      if (we && int'(wa) < nregs(d)) begin
        m_mem[d][wa]  = merge32(m_mem[d][wa], wd, wbe);
        m_busy[d][wa] = 1'b0;
      end
      if (re && int'(ra) < nregs(d)) m_busy[d][ra] = 1'b1;
    end
    q_busy.push_back(m_busy[d]);

    @(posedge clk);
    #1;
    e = q_a.pop_front();
    check("rdA_valid", 64'(d ? c_rd_valid_a : rd_valid_a), 64'(e.v));
    check("rdA_data",  64'(d ? c_rd_data_a : {16'h0, rd_data_a}), 64'(e.d));
    e = q_b.pop_front();
    check("rdB_valid", 64'(d ? c_rd_valid_b : rd_valid_b), 64'(e.v));
    check("rdB_data",  64'(d ? c_rd_data_b : {16'h0, rd_data_b}), 64'(e.d));
    check("busy", 64'(d ? {2'b00, c_busy} : busy), 64'(q_busy.pop_front()));
  endtask

  initial begin
    // ---------------- 8 x 16 instance ----------------
    step(0, Y, N, 3'd0, N, 3'd0, N, 3'd0, 32'h0, 4'h0, N, 3'd0);
    for (int i = 0; i < 8; i++)
      step(0, N, Y, 3'(i), Y, 3'(7 - i), N, 3'd0, 32'h0, 4'h0, N, 3'd0);
    // byte-lane writes to r3
    step(0, N, N, 3'd0, N, 3'd0, Y, 3'd3, 32'h1234, 4'h3, N, 3'd0);
    step(0, N, N, 3'd0, N, 3'd0, Y, 3'd3, 32'habcd, 4'h1, N, 3'd0);
    step(0, N, Y, 3'd3, N, 3'd0, N, 3'd0, 32'h0,    4'h0, N, 3'd0);
    step(0, N, N, 3'd0, Y, 3'd3, Y, 3'd3, 32'hff00, 4'h2, N, 3'd0);
    step(0, N, Y, 3'd3, N, 3'd0, Y, 3'd3, 32'h0000, 4'h0, N, 3'd0);
    // same-cycle write/read bypass on r5
    step(0, N, Y, 3'd5, N, 3'd0, Y, 3'd5, 32'h5a5a, 4'h3, N, 3'd0);
    // reserve r2 (same-cycle read unaffected), stalled read, then producer write
    step(0, N, Y, 3'd2, N, 3'd0, N, 3'd0, 32'h0,    4'h0, Y, 3'd2);
    step(0, N, N, 3'd0, Y, 3'd2, N, 3'd0, 32'h0,    4'h0, N, 3'd0);
    step(0, N, N, 3'd0, Y, 3'd2, Y, 3'd2, 32'h0042, 4'h3, N, 3'd0);
    // reserve and write to r6 together: reserve wins, data still lands
    step(0, N, N, 3'd0, N, 3'd0, Y, 3'd6, 32'h6666, 4'h3, Y, 3'd6);
    step(0, N, Y, 3'd6, N, 3'd0, N, 3'd0, 32'h0,    4'h0, N, 3'd0);
    step(0, N, Y, 3'd6, N, 3'd0, Y, 3'd6, 32'h0,    4'h0, N, 3'd0);
    // both ports on the same register
    step(0, N, Y, 3'd5, Y, 3'd5, N, 3'd0, 32'h0,    4'h0, N, 3'd0);
    for (int i = 0; i < 60; i++)
      step(0, N, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom),
           4'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));

    // ---------------- 6 x 32 instance ----------------
    step(1, Y, N, 3'd0, N, 3'd0, N, 3'd0, 32'h0, 4'h0, N, 3'd0);
    step(1, N, N, 3'd0, N, 3'd0, Y, 3'd1, 32'hdeadbeef, 4'hf, N, 3'd0);
    // write and reserve to address 7 are ignored; read of 7 returns zero, valid
    step(1, N, Y, 3'd7, Y, 3'd1, Y, 3'd7, 32'hffffffff, 4'hf, Y, 3'd7);
    step(1, N, Y, 3'd6, Y, 3'd7, N, 3'd0, 32'h0, 4'h0, N, 3'd0);
    step(1, N, N, 3'd0, Y, 3'd5, Y, 3'd5, 32'h12345678, 4'h5, N, 3'd0);
    step(1, N, Y, 3'd4, N, 3'd0, N, 3'd0, 32'h0, 4'h0, Y, 3'd4);
    step(1, N, Y, 3'd4, Y, 3'd5, N, 3'd0, 32'h0, 4'h0, N, 3'd0);
    // reset mid-stream with requests in flight
    step(1, Y, Y, 3'd1, Y, 3'd5, Y, 3'd0, 32'h11111111, 4'hf, Y, 3'd3);
    step(1, N, Y, 3'd1, Y, 3'd5, N, 3'd0, 32'h0, 4'h0, N, 3'd0);
    for (int i = 0; i < 40; i++)
      step(1, N, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom),
           4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
